mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Memory-side responder for the CPU byte bus (mem_a/mem_dout/mem_wr in, mem_din/io_buffer_full out).
- Provides 128KB-class synchronous RAM plus the memory-mapped I/O page: UART TX/RX byte FIFOs, a free-running cycle counter, and a program-stop flag.
- Used as the memory model in simulation and as the memory/IO shim between the core and the UART in FPGA builds.

Parameters:
- ADDR_W, 17, RAM address bits; RAM holds 2^ADDR_W bytes.
- TX_DEPTH, 16, TX FIFO entries (power of 2, >=4).
- RX_DEPTH, 16, RX FIFO entries (power of 2, >=2).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- mem_a  input  32  CPU address; only [17:0] decoded
- mem_dout  input  8  CPU write data
- mem_wr  input  1  1 = write, 0 = read
- mem_din  output  8  read data to CPU, valid the cycle after the read address
- io_buffer_full  output  1  TX FIFO near-full back-pressure to CPU
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  TX FIFO non-empty
- tx_ready  input  1  UART accepts tx_data when tx_valid & tx_ready
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  RX FIFO not full
- prog_stop  output  1  sticky program-finished flag
- tx_overflow  output  1  sticky: a TX byte was dropped because the FIFO was full

Behaviour:
- Reset (rst_in low, async): mem_din=0, io_buffer_full=0, tx_valid=0, rx_ready=1, prog_stop=0, tx_overflow=0.
  - Reset also clears the counter, the snapshot, and the FIFO pointers.
  - RAM contents are not cleared.
  - A reset mid-operation discards any pending read result.
- Decode:
  - IO when mem_a[17:16]==2'b11; otherwise RAM at mem_a[ADDR_W-1:0].
  - Upper address bits are ignored.
- RAM:
  - Read: mem_din <= ram[addr] on the next edge (1-cycle latency, every cycle, no handshake).
  - Write: ram[addr] <= mem_dout at the edge.
  - A read issued the cycle after a write to the same address returns the new value.
- mem_din is registered and holds its value when the current cycle is a write.
- IO read 0x30000:
  - RX FIFO non-empty: pop one byte, return it next cycle.
  - RX FIFO empty: return 0x00 with no pop.
- IO read 0x30004..0x30007: return byte (addr[1:0]) of the counter, little-endian.
  - A read of 0x30004 captures counter into snapshot and returns counter[7:0].
  - Reads of 0x30005..7 return bytes of the snapshot, so a 4-byte read sequence is coherent.
- Other IO read addresses return 0x00.
- IO write 0x30000:
  - Data 0x00: ignored.
  - Otherwise push to TX FIFO.
  - If the TX FIFO is full, drop the byte and set tx_overflow.
- IO write 0x30004:
  - Set prog_stop.
  - Push 0x00 to the TX FIFO (same full rule).
  - Freeze the counter.
- Other IO writes are ignored.
- Counter: 32-bit, +1 per clock from reset until prog_stop, wraps 0xFFFFFFFF -> 0.
- TX FIFO:
  - tx_valid = count!=0; pop on tx_valid & tx_ready.
  - Push and pop in the same cycle: count unchanged, both take effect. This is legal when full.
- io_buffer_full: registered; 1 when next-cycle TX count >= TX_DEPTH-2.
  - The 2-entry headroom absorbs a CPU write already in flight.
- RX FIFO:
  - rx_ready = count!=RX_DEPTH.
  - Push on rx_valid & rx_ready.
  - Simultaneous push and a CPU pop (read of 0x30000) in one cycle are both honoured.
  - Pop on empty returns 0x00 even if a push lands in that same cycle; the pushed byte is returned on the next read.
- Pointers wrap modulo depth; count width is clog2(depth)+1.

Test Plan:
- RAM: write 0xA5 @0x00010, then read 0x00010 next cycle -> mem_din==0xA5 one cycle later. Read 0x1FFFF after writing 0x3C there -> 0x3C.
- TX: writes 'H'(0x48), 0x00, 'i'(0x69) to 0x30000 with tx_ready=1 -> tx_data sequence 0x48, 0x69; the 0x00 is never seen.
- Back-pressure: tx_ready=0, TX_DEPTH=16:
  - 14 writes -> io_buffer_full=1 after the 14th.
  - 17th write -> tx_overflow=1, FIFO count stays 16.
  - tx_ready=1 -> io_buffer_full drops at count<=13.
- RX: push 0x31, 0x32 via rx_valid. Reads of 0x30000 return 0x31, then 0x32, then 0x00 (empty).
- Counter: 100 cycles after reset, read 0x30004..7 over 4 cycles -> the bytes assemble to the snapshot value (≈100). Bytes 1..3 match the snapshot, not the live counter.
- Stop: write 0x30004 -> prog_stop=1, counter frozen, tx_data 0x00 emitted. Assert rst_in=0 mid-run -> prog_stop=0, mem_din=0 immediately (asynchronous).

Source files
------------

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus UART byte streams seen by the memory/IO responder.
// The master side is the CPU core together with the UART.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_stop;
  logic        tx_overflow;

  modport master (
    output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, prog_stop, tx_overflow
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, prog_stop, tx_overflow
  );
endinterface

// File: rtl/mem_io_responder.sv
// Synchronous byte RAM plus IO page (UART TX/RX FIFOs, cycle counter, stop flag)
// answering the CPU byte bus with one cycle of read latency.
module mem_io_responder #(
  parameter int ADDR_W   = 17,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_io_responder_if.slave bus
);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam logic [TXA:0]   TX_FULL = (TXA+1)'(TX_DEPTH);
  localparam logic [TXA:0]   TX_HIGH = (TXA+1)'(TX_DEPTH - 2);
  localparam logic [TXA:0]   TX_ONE  = (TXA+1)'(1);
  localparam logic [TXA-1:0] TXP_ONE = TXA'(1);
  localparam logic [RXA:0]   RX_FULL = (RXA+1)'(RX_DEPTH);
  localparam logic [RXA:0]   RX_ONE  = (RXA+1)'(1);
  localparam logic [RXA-1:0] RXP_ONE = RXA'(1);

  logic [17:0]       addr;
  logic              unused_addr;
  logic              rd, wr, is_io, io_uart, io_cnt, stop_wr, ram_we;
  logic [ADDR_W-1:0] ram_addr;

  logic [7:0] ram [2**ADDR_W];
  logic [7:0] ram_rd_q;
  logic       sel_ram_q, sel_ram_d;
  logic [7:0] io_rd_q, io_rd_d;

  logic [31:0] cnt_q, cnt_d;
  logic [31:8] snap_q, snap_d;
  logic        stop_q, stop_d;
  logic        ovf_q, ovf_d;
  logic        io_full_q, io_full_d;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TXA-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TXA:0]   tx_cnt_q, tx_cnt_d;
  logic           tx_req, tx_push, tx_pop, tx_drop;
  logic [7:0]     tx_push_data;

  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RXA-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RXA:0]   rx_cnt_q, rx_cnt_d;
  logic           rx_push, rx_pop;

  assign addr        = bus.mem_a[17:0];
  assign unused_addr = ^bus.mem_a[31:18];
  assign wr          = bus.mem_wr;
  assign rd          = ~bus.mem_wr;
  assign is_io       = (addr[17:16] == 2'b11);
  assign io_uart     = is_io && (addr[15:0] == 16'h0000);
  assign io_cnt      = is_io && (addr[15:2] == 14'h0001);
  assign stop_wr     = wr && io_cnt && (addr[1:0] == 2'b00);
  assign ram_addr    = addr[ADDR_W-1:0];
  assign ram_we      = wr && !is_io;

  // A full FIFO still accepts a push when a pop drains an entry on the same edge.
  assign tx_req       = (wr && io_uart && (bus.mem_dout != 8'h00)) || stop_wr;
  assign tx_push_data = stop_wr ? 8'h00 : bus.mem_dout;
  assign tx_pop       = (tx_cnt_q != '0) && bus.tx_ready;
  assign tx_push      = tx_req && ((tx_cnt_q != TX_FULL) || tx_pop);
  assign tx_drop      = tx_req && (tx_cnt_q == TX_FULL) && !tx_pop;

  assign rx_push = bus.rx_valid && bus.rx_ready;
  assign rx_pop  = rd && io_uart && (rx_cnt_q != '0);

  always_comb begin
    tx_wr_d  = tx_push ? tx_wr_q + TXP_ONE : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + TXP_ONE : tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - TX_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    io_full_d = (tx_cnt_d >= TX_HIGH);
  end

  always_comb begin
    rx_wr_d  = rx_push ? rx_wr_q + RXP_ONE : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + RXP_ONE : rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - RX_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // Byte 0 read latches the snapshot so bytes 1..3 form a coherent value.
  always_comb begin
    io_rd_d   = io_rd_q;
    sel_ram_d = sel_ram_q;
    snap_d    = snap_q;
    if (rd) begin
      sel_ram_d = !is_io;
      io_rd_d   = 8'h00;
      if (io_uart) begin
        if (rx_pop) io_rd_d = rx_mem[rx_rd_q];
      end else if (io_cnt) begin
        case (addr[1:0])
          2'b00: begin
            io_rd_d = cnt_q[7:0];
            snap_d  = cnt_q[31:8];
          end
          2'b01:   io_rd_d = snap_q[15:8];
          2'b10:   io_rd_d = snap_q[23:16];
          default: io_rd_d = snap_q[31:24];
        endcase
      end
    end
  end

  always_comb begin
    stop_d = stop_q || stop_wr;
    ovf_d  = ovf_q || tx_drop;
    cnt_d  = (stop_q || stop_wr) ? cnt_q : cnt_q + 32'd1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_ram_q <= 1'b0;
      io_rd_q   <= 8'h00;
      cnt_q     <= '0;
      snap_q    <= '0;
      stop_q    <= 1'b0;
      ovf_q     <= 1'b0;
      io_full_q <= 1'b0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      sel_ram_q <= sel_ram_d;
      io_rd_q   <= io_rd_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      stop_q    <= stop_d;
      ovf_q     <= ovf_d;
      io_full_q <= io_full_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // Storage arrays carry no reset; pointers alone define FIFO contents.
  always_ff @(posedge clk_in) begin
    if (ram_we)  ram[ram_addr]    <= bus.mem_dout;
    if (rd)      ram_rd_q         <= ram[ram_addr];
    if (tx_push) tx_mem[tx_wr_q]  <= tx_push_data;
    if (rx_push) rx_mem[rx_wr_q]  <= bus.rx_data;
  end

  assign bus.mem_din        = sel_ram_q ? ram_rd_q : io_rd_q;
  assign bus.io_buffer_full = io_full_q;
  assign bus.tx_data        = tx_mem[tx_rd_q];
  assign bus.tx_valid       = (tx_cnt_q != '0);
  assign bus.rx_ready       = (rx_cnt_q != RX_FULL);
  assign bus.prog_stop      = stop_q;
  assign bus.tx_overflow    = ovf_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a reference model predicts every output each
// cycle; TX bytes go through a scoreboard queue popped when the UART accepts them.
module tb_mem_io_responder;
  localparam logic [31:0] IDLE = 32'h0003_0008;
  localparam logic [31:0] UART = 32'h0003_0000;
  localparam logic [31:0] CNT0 = 32'h0003_0004;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  mem_io_responder_if bus();

  mem_io_responder #(.ADDR_W(17), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  tx_exp [$];
  logic [7:0]  rx_m [$];
  logic [7:0]  ram_m [int];
  logic [7:0]  din_m;
  logic [31:0] cnt_m, snap_m, asm_v;
  logic        stop_m, ovf_m;
  logic        txr_v, rxv_v;
  logic [7:0]  rxd_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("mem_din",        32'(bus.mem_din),        32'(din_m));
    check("io_buffer_full", 32'(bus.io_buffer_full), 32'(tx_exp.size() >= 14));
    check("tx_overflow",    32'(bus.tx_overflow),    32'(ovf_m));
    check("prog_stop",      32'(bus.prog_stop),      32'(stop_m));
    check("tx_valid",       32'(bus.tx_valid),       32'(tx_exp.size() != 0));
    check("rx_ready",       32'(bus.rx_ready),       32'(rx_m.size() != 16));
  endtask

  task automatic reset_model();
    tx_exp.delete();
    rx_m.delete();
    din_m  = 8'h00;
    cnt_m  = 32'h0;
    snap_m = 32'h0;
    stop_m = 1'b0;
    ovf_m  = 1'b0;
  endtask

  // One bus cycle: drive, predict the coming edge, then check after it.
  task automatic cycle(input logic [31:0] a, input logic w, input logic [7:0] d);
    logic        is_io, rx_rdy, tx_pop, push, stopwr;
    logic [15:0] off;
    logic [7:0]  pd;
    bus.mem_a    = a;
    bus.mem_wr   = w;
    bus.mem_dout = d;
    bus.tx_ready = txr_v;
    bus.rx_valid = rxv_v;
    bus.rx_data  = rxd_v;
    rx_rdy = (rx_m.size() < 16);
    tx_pop = (tx_exp.size() != 0) && txr_v;
    if (tx_pop) check("tx_data", 32'(bus.tx_data), 32'(tx_exp.pop_front()));
    is_io  = (a[17:16] == 2'b11);
    off    = a[15:0];
    push   = 1'b0;
    pd     = 8'h00;
    stopwr = 1'b0;
    if (!w) begin
      if (!is_io)            din_m = ram_m[int'(a[16:0])];
      else if (off == 16'h0) din_m = (rx_m.size() != 0) ? rx_m.pop_front() : 8'h00;
      else if (off == 16'h4) begin snap_m = cnt_m; din_m = cnt_m[7:0]; end
      else if (off == 16'h5) din_m = snap_m[15:8];
      else if (off == 16'h6) din_m = snap_m[23:16];
      else if (off == 16'h7) din_m = snap_m[31:24];
      else                   din_m = 8'h00;
    end else begin
      if (!is_io) ram_m[int'(a[16:0])] = d;
      else if (off == 16'h0 && d != 8'h00) begin push = 1'b1; pd = d; end
      else if (off == 16'h4) begin push = 1'b1; pd = 8'h00; stopwr = 1'b1; end
    end
    if (push) begin
      if (tx_exp.size() < 16) tx_exp.push_back(pd);
      else ovf_m = 1'b1;
    end
    if (rxv_v && rx_rdy) rx_m.push_back(rxd_v);
    if (!(stop_m || stopwr)) cnt_m = cnt_m + 32'd1;
    stop_m = stop_m || stopwr;
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic async_reset();
    bus.mem_a    = IDLE;
    bus.mem_wr   = 1'b0;
    bus.rx_valid = 1'b0;
    rxv_v        = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    reset_model();
    check_outputs();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic read_counter();
    asm_v = 32'h0;
    for (int i = 0; i < 4; i++) begin
      cycle(CNT0 + 32'(i), 1'b0, 8'h00);
      asm_v[8*i +: 8] = bus.mem_din;
    end
    check("counter_snapshot", asm_v, snap_m);
  endtask

  initial begin
    txr_v = 1'b0; rxv_v = 1'b0; rxd_v = 8'h00;
    bus.mem_a = IDLE; bus.mem_wr = 1'b0; bus.mem_dout = 8'h00;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    reset_model();
    repeat (3) @(negedge clk_in);
    check_outputs();
    rst_in = 1'b1;

    // RAM, including read-after-write, top address and ignored upper bits
    cycle(32'h0000_0010, 1'b1, 8'hA5);
    cycle(32'h0000_0010, 1'b0, 8'h00);
    cycle(32'h0001_FFFF, 1'b1, 8'h3C);
    cycle(32'h0001_FFFF, 1'b0, 8'h00);
    cycle(32'hFFF0_0010, 1'b0, 8'h00);
    cycle(32'h0000_0010, 1'b1, 8'h5A);
    cycle(32'h0002_0010, 1'b0, 8'h00);
    cycle(IDLE, 1'b0, 8'h00);

    // TX stream with a zero byte that must be swallowed
    txr_v = 1'b1;
    cycle(UART, 1'b1, 8'h48);
    cycle(UART, 1'b1, 8'h00);
    cycle(UART, 1'b1, 8'h69);
    repeat (4) cycle(IDLE, 1'b0, 8'h00);

    // Back-pressure, overflow, push+pop while full, then drain
    txr_v = 1'b0;
    for (int i = 0; i < 17; i++) cycle(UART, 1'b1, 8'(8'h41 + i));
    txr_v = 1'b1;
    cycle(UART, 1'b1, 8'h7E);
    repeat (20) cycle(IDLE, 1'b0, 8'h00);

    // RX basic, pop-on-empty with simultaneous push, fill to full
    rxv_v = 1'b1; rxd_v = 8'h31; cycle(IDLE, 1'b0, 8'h00);
    rxd_v = 8'h32;               cycle(IDLE, 1'b0, 8'h00);
    rxv_v = 1'b0;
    repeat (3) cycle(UART, 1'b0, 8'h00);
    rxv_v = 1'b1; rxd_v = 8'h33; cycle(UART, 1'b0, 8'h00);
    rxv_v = 1'b0;
    repeat (2) cycle(UART, 1'b0, 8'h00);
    rxv_v = 1'b1;
    for (int i = 0; i < 18; i++) begin
      rxd_v = 8'(8'h80 + i);
      cycle(IDLE, 1'b0, 8'h00);
    end
    rxd_v = 8'hEE;
    cycle(UART, 1'b0, 8'h00);
    rxv_v = 1'b0;
    repeat (17) cycle(UART, 1'b0, 8'h00);

    // Counter: 100 cycles after reset, then a snapshot across a byte-1 carry
    async_reset();
    repeat (100) cycle(IDLE, 1'b0, 8'h00);
    read_counter();
    for (int i = 0; i < 300 && cnt_m != 32'hFF; i++) cycle(IDLE, 1'b0, 8'h00);
    read_counter();

    // Stop: flag, 0x00 on TX, frozen counter
    txr_v = 1'b1;
    cycle(CNT0, 1'b1, 8'h55);
    repeat (2) cycle(IDLE, 1'b0, 8'h00);
    read_counter();
    repeat (10) cycle(IDLE, 1'b0, 8'h00);
    read_counter();

    // Mid-run async reset: outputs clear at once, RAM survives
    cycle(32'h0000_0010, 1'b0, 8'h00);
    async_reset();
    cycle(IDLE, 1'b0, 8'h00);
    cycle(32'h0000_0010, 1'b0, 8'h00);
    cycle(IDLE, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
